// File: rtl/encoder4to2_seq_pkg.sv
// Shared constants and FSM state encoding for the sequential 4-to-2 priority encoder.
package encoder4to2_seq_pkg;

  localparam int unsigned ReqWidth  = 4;
  localparam int unsigned CodeWidth = 2;

  localparam logic [CodeWidth-1:0] IdleCode = 2'b11;

  typedef enum logic {
    StIdle    = 1'b0,
    StPresent = 1'b1
  } state_e;

endpackage

// File: rtl/encoder4to2_seq_if.sv
// Request/code bundle between a request producer/consumer and the encoder.
interface encoder4to2_seq_if;
  import encoder4to2_seq_pkg::*;

  logic                 ei_n;
  logic [ReqWidth-1:0]  req_n;
  logic                 ack;
  logic [CodeWidth-1:0] y_n;
  logic                 gs_n;
  logic                 eo_n;

  modport master (
    output ei_n,
    output req_n,
    output ack,
    input  y_n,
    input  gs_n,
    input  eo_n
  );

  modport slave (
    input  ei_n,
    input  req_n,
    input  ack,
    output y_n,
    output gs_n,
    output eo_n
  );

endinterface

// File: rtl/encoder4to2_seq_prio4.sv
// Combinational highest-set-bit finder over four lines.
module prio4 (
  input  logic [3:0] vec,
  output logic [1:0] idx,
  output logic       any
);

  always_comb begin
    idx = 2'd0;
    if (vec[3]) begin
      idx = 2'd3;
    end else if (vec[2]) begin
      idx = 2'd2;
    end else if (vec[1]) begin
      idx = 2'd1;
    end
    any = |vec;
  end

endmodule

// File: rtl/encoder4to2_seq.sv
// Sticky-request priority encoder: captures active-low requests, presents one code at a time
// and holds it until acknowledged.
module encoder4to2_seq
  import encoder4to2_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  encoder4to2_seq_if.slave    bus
);

  state_e               state_q, state_d;
  logic [ReqWidth-1:0]  pending_q, pending_d;
  logic [ReqWidth-1:0]  set_mask, clr_mask;
  logic [CodeWidth-1:0] code_q, code_d;
  logic [CodeWidth-1:0] y_n_q, y_n_d;
  logic                 gs_n_q, gs_n_d;
  logic [CodeWidth-1:0] top_idx;
  logic                 any_pending;

  prio4 u_prio4 (
    .vec (pending_q),
    .idx (top_idx),
    .any (any_pending)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    y_n_d    = y_n_q;
    gs_n_d   = gs_n_q;
    clr_mask = '0;
    unique case (state_q)
      StIdle: begin
        if (any_pending) begin
          state_d = StPresent;
          code_d  = top_idx;
          y_n_d   = ~top_idx;
          gs_n_d  = 1'b0;
        end
      end
      StPresent: begin
        if (bus.ack) begin
          state_d          = StIdle;
          clr_mask[code_q] = 1'b1;
          y_n_d            = IdleCode;
          gs_n_d           = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // A request re-asserted on the ack edge survives the clear.
    set_mask  = bus.ei_n ? '0 : ~bus.req_n;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= '0;
      code_q    <= '0;
      y_n_q     <= IdleCode;
      gs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      y_n_q     <= y_n_d;
      gs_n_q    <= gs_n_d;
    end
  end

  assign bus.y_n  = y_n_q;
  assign bus.gs_n = gs_n_q;
  assign bus.eo_n = ~(~bus.ei_n & (pending_q == '0) & (state_q == StIdle));

endmodule

// File: tb/tb_encoder4to2_seq.sv
// Scoreboard bench: a request-set model predicts each presented code; a monitor checks outputs.
module tb_encoder4to2_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  encoder4to2_seq_if bus ();

  encoder4to2_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  bit         pend[4];
  bit         pres     = 1'b0;
  int         cur      = 0;
  bit         model_ok = 1'b0;
  bit         prev_gs  = 1'b1;
  logic [1:0] exp_q[$];

  function automatic int highest();
    for (int i = 3; i >= 0; i--) begin
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit pend_empty();
    return !(pend[0] || pend[1] || pend[2] || pend[3]);
  endfunction

  function automatic void chk(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  // Request-set model, evaluated once per rising edge from the inputs just sampled.
  task automatic model_update();
    bit nxt[4];
    int h;
    if (rst) begin
      foreach (pend[i]) pend[i] = 1'b0;
      pres = 1'b0;
    end else begin
      nxt = pend;
      if (pres) begin
        if (bus.ack) begin
          nxt[cur] = 1'b0;
          pres     = 1'b0;
        end
      end else begin
        h = highest();
        if (h >= 0) begin
          pres = 1'b1;
          cur  = h;
          exp_q.push_back(2'(3 - h));
        end
      end
      if (!bus.ei_n) begin
        for (int i = 0; i < 4; i++) begin
          if (!bus.req_n[i]) nxt[i] = 1'b1;
        end
      end
      pend = nxt;
    end
    model_ok = 1'b1;
  endtask

  task automatic step(input bit r, input bit e, input logic [3:0] q, input bit a);
    @(negedge clk);
    #1;
    rst       = r;
    bus.ei_n  = e;
    bus.req_n = q;
    bus.ack   = a;
    @(posedge clk);
    model_update();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b1111, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [1:0] want;
    if (model_ok) begin
      chk("gs_n", {1'b0, bus.gs_n}, {1'b0, !pres});
      chk("y_n", bus.y_n, pres ? 2'(3 - cur) : 2'b11);
      chk("eo_n", {1'b0, bus.eo_n}, {1'b0, !(!bus.ei_n && pend_empty() && !pres)});
      if (!bus.gs_n && prev_gs) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got code %b expected none at %0t", bus.y_n, $time);
        end else begin
          want = exp_q.pop_front();
          chk("sb_code", bus.y_n, want);
        end
      end
      prev_gs = bus.gs_n;
    end
  end

  initial begin
    bus.ei_n  = 1'b0;
    bus.req_n = 4'b0000;
    bus.ack   = 1'b0;

    // Reset with requests asserted: nothing captured.
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 4'b0000, 1'b0);
    idle(2);

    // Single request on index 2.
    step(1'b0, 1'b0, 4'b1011, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 4'b1111, 1'b1);
    idle(2);

    // Two requests at once: index 3 then index 0.
    step(1'b0, 1'b0, 4'b0110, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 4'b1111, 1'b1);
    idle(3);
    step(1'b0, 1'b0, 4'b1111, 1'b1);
    idle(2);

    // Higher request arrives while index 1 is presented.
    step(1'b0, 1'b0, 4'b1101, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 4'b0111, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 4'b1111, 1'b1);
    idle(3);
    step(1'b0, 1'b0, 4'b1111, 1'b1);
    idle(2);

    // Disabled: no capture.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b0000, 1'b0);
    idle(3);

    // Ack coincident with re-assertion of the presented request.
    step(1'b0, 1'b0, 4'b1011, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 4'b1011, 1'b1);
    idle(3);
    step(1'b0, 1'b0, 4'b1111, 1'b1);
    idle(2);

    // Reset while presenting discards the code.
    step(1'b0, 1'b0, 4'b1110, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 4'b1111, 1'b0);
    idle(4);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] q;
      for (int b = 0; b < 4; b++) q[b] = ($urandom_range(0, 5) != 0);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0), q,
           ($urandom_range(0, 2) == 0));
    end
    idle(4);

    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d unmatched codes expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/encoder4to2_seq.md
ENCODER4TO2_SEQ -- requirements
Module: encoder4to2_seq

Interface
REQ-001 The block SHALL have one parameter: none; all widths are fixed (4 request lines, 2-bit code).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ei_n  input  1  enable input, active-low; high blocks capture of new requests.
REQ-005 req_n  input  4  request lines, active-low; bit 3 highest priority, bit 0 lowest.
REQ-006 ack  input  1  consumer acceptance of the presented code, active-high, one-cycle pulse or level.
REQ-007 y_n  output  2  encoded index of presented request, active-low (index 3 -> 2'b00, index 0 -> 2'b11).
REQ-008 gs_n  output  1  group-select, active-low; low exactly while a valid code is presented.
REQ-009 eo_n  output  1  enable output, active-low; low when ei_n low, no request pending, nothing presented.

Function
REQ-010 The block SHALL hold a 4-bit sticky pending register; at each edge with ei_n low, pending[i] SHALL set if req_n[i] is low.
REQ-011 With ei_n high, no pending bit SHALL set; existing pending bits and any presentation SHALL be retained.
REQ-012 The FSM SHALL have two states: IDLE (nothing presented) and PRESENT (code held).
REQ-013 IDLE -> PRESENT at an edge where pending (registered value before that edge) is non-zero; code = highest set pending index.
REQ-014 Latency: req_n[i] low sampled at edge k, pending set at k, gs_n low and y_n valid after edge k+1 (two-edge latency).
REQ-015 In PRESENT, y_n and gs_n SHALL remain stable until ack is sampled high; a newly arriving higher-priority request SHALL NOT pre-empt.
REQ-016 PRESENT with ack high at an edge: pending[code] SHALL clear, state -> IDLE, gs_n high and y_n = 2'b11 after that edge.
REQ-017 Simultaneous ack and re-assertion of req_n[code] (ei_n low): pending[code] SHALL remain set (set wins over clear).
REQ-018 After an ack, the next presentation SHALL begin no earlier than one IDLE cycle later (one bubble cycle between codes).
REQ-019 ack sampled in IDLE SHALL be ignored.
REQ-020 In IDLE, y_n SHALL be 2'b11 and gs_n SHALL be high.
REQ-021 eo_n SHALL be combinational: low iff ei_n low, pending == 0 and state IDLE; otherwise high.

Reset
REQ-022 rst high at an edge SHALL clear pending to 0, force IDLE, y_n = 2'b11, gs_n = 1, regardless of ei_n, req_n or ack.
REQ-023 rst asserted during PRESENT SHALL discard the presented code without requiring ack.
REQ-024 Requests low during the reset edge SHALL NOT be captured; capture resumes on the first edge with rst low.

Structure
REQ-025 The shared package SHALL hold the FSM state encodings (IDLE, PRESENT), the idle code constant 2'b11 and the request width 4.
REQ-026 The highest-index selection SHALL be a combinational sub-module prio4 (4-bit in, 2-bit index out, any-set flag out).
REQ-027 y_n and gs_n SHALL be driven directly from registers (no combinational path from req_n).

Verification
REQ-028 Reset: rst=1 two cycles with req_n=4'b0000, ei_n=0 -> y_n=2'b11, gs_n=1, pending=0 after reset release edge.
REQ-029 Single request: ei_n=0, req_n=4'b1011 one cycle -> gs_n=0, y_n=2'b01 two edges later; ack=1 one cycle -> gs_n=1, y_n=2'b11, eo_n=0.
REQ-030 Priority order: req_n=4'b0110 one cycle -> codes presented in order y_n=2'b00 then 2'b11 (indices 3 then 0), each held until ack, one bubble between.
REQ-031 No pre-emption: presenting index 1, assert req_n[3] low -> y_n stays 2'b10 until ack; then index 3 (y_n=2'b00) presented.
REQ-032 Disable: ei_n=1, req_n=4'b0000 for 5 cycles -> gs_n stays 1, eo_n=1; ei_n=0 afterward with req_n=4'b1111 -> eo_n=0, no code presented.
REQ-033 Set-wins and mid-reset: ack coincident with re-asserted req_n[2] -> index 2 re-presented after bubble; rst=1 during PRESENT -> gs_n=1, y_n=2'b11 next edge, no further codes.
